serial_adder: RTL and testbench

- Parametrised bit-serial adder. Adds two WIDTH-bit operands plus carry-in, one bit per clock, LSB first.
- Successor to the combinational half-adder: a single 1-bit full-adder cell is reused across WIDTH cycles under a start/busy/done FSM.
- Used as a low-area adder in datapaths where latency is acceptable.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/fa_bit.sv | 38 +++
 rtl/half_adder.sv | 20 ++
 rtl/serial_adder.sv | 126 ++++++++++++
 tb/tb_serial_adder.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/serial_adder_pkg.sv
//------------------------------------------------------------------------------
// Module   : serial_adder_pkg
// Brief    : Shared state encoding and default width for the bit-serial adder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package serial_adder_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Encoding 2'd3 is unreachable and is handled as IDLE by the top.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/fa_bit.sv
//------------------------------------------------------------------------------
// Module   : fa_bit
// Brief    : Combinational 1-bit full adder built from two half adders.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fa_bit (
    input  logic a_i,
    input  logic b_i,
    input  logic ci_i,
    output logic s_o,
    output logic co_o
);

    logic w_s0;
    logic w_c0;
    logic w_c1;

    half_adder u_ha0 (
        .a_i (a_i),
        .b_i (b_i),
        .s_o (w_s0),
        .c_o (w_c0)
    );

    half_adder u_ha1 (
        .a_i (w_s0),
        .b_i (ci_i),
        .s_o (s_o),
        .c_o (w_c1)
    );

    assign co_o = w_c0 | w_c1;

endmodule

`default_nettype wire

// File: rtl/half_adder.sv
//------------------------------------------------------------------------------
// Module   : half_adder
// Brief    : Combinational 1-bit half adder.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module half_adder (
    input  logic a_i,
    input  logic b_i,
    output logic s_o,
    output logic c_o
);

    assign s_o = a_i ^ b_i;
    assign c_o = a_i & b_i;

endmodule

`default_nettype wire

// File: rtl/serial_adder.sv
//------------------------------------------------------------------------------
// Module   : serial_adder
// Brief    : Bit-serial adder, LSB first, one full-adder cell reused WIDTH
//            cycles. Define SERIAL_ADDER_OVF_EN to add the signed-overflow port.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [WIDTH-1:0] sha_q;
    logic [WIDTH-1:0] shb_q;
    logic [WIDTH-1:0] sum_q;
    logic [CNT_W-1:0] cnt_q;
    logic             carry_q;
    logic             cout_q;
    logic             busy_q;
    logic             done_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    logic             w_bit_s;
    logic             w_bit_co;
    logic             w_last;

    fa_bit u_fa (
        .a_i  (sha_q[0]),
        .b_i  (shb_q[0]),
        .ci_i (carry_q),
        .s_o  (w_bit_s),
        .co_o (w_bit_co)
    );

    assign w_last = (cnt_q == C_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sha_q   <= '0;
            shb_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            case (state_q)
                RUN: begin
                    sha_q   <= sha_q >> 1;
                    shb_q   <= shb_q >> 1;
                    sum_q   <= {w_bit_s, sum_q[WIDTH-1:1]};
                    carry_q <= w_bit_co;
                    cnt_q   <= cnt_q + CNT_W'(1);
                    if (w_last) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cout_q  <= w_bit_co;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q here is the carry into the MSB cell
                        ovf_q   <= carry_q ^ w_bit_co;
`endif
                    end
                end
                default: begin
                    // IDLE, DONE and the unreachable encoding all accept start
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                        sha_q   <= a;
                        shb_q   <= b;
                        carry_q <= cin;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        cout_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
                        ovf_q   <= 1'b0;
`endif
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign sum  = sum_q;
    assign cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_serial_adder.sv
//------------------------------------------------------------------------------
// Module   : tb_serial_adder
// Brief    : Self-checking bench for serial_adder (WIDTH=8), vector table plus
//            handshake corner cases. Honours SERIAL_ADDER_OVF_EN.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_serial_adder;

    localparam int WIDTH = 8;
    localparam int NV    = 9;

    typedef struct packed {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } res_t;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } vec_t;

    logic             clk   = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             cin   = 1'b0;
    logic [WIDTH-1:0] a     = '0;
    logic [WIDTH-1:0] b     = '0;
    logic             busy;
    logic             done;
    logic             cout;
    logic [WIDTH-1:0] sum;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;
`endif

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    res_t exp_q[$];
    vec_t vec[NV];

    serial_adder #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic res_t model(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                   input logic c);
        logic [WIDTH:0] t;
        res_t           r;
        t      = {1'b0, x} + {1'b0, y} + {{WIDTH{1'b0}}, c};
        r.sum  = t[WIDTH-1:0];
        r.cout = t[WIDTH];
        r.ovf  = (x[WIDTH-1] == y[WIDTH-1]) && (t[WIDTH-1] != x[WIDTH-1]);
        return r;
    endfunction

    // Result monitor: pops the scoreboard whenever done pulses
    initial begin
        res_t e;
        forever begin
            @(negedge clk);
            if (busy === 1'b1 && done === 1'b1) begin
                n_errors++;
                $display("FAIL busy_done_overlap: got busy=1 done=1, expected at most one high");
            end
            if (done === 1'b1) begin
                done_cnt++;
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_done: got done=1, expected no pending result");
                end else begin
                    e = exp_q.pop_front();
                    chk("sum", sum, e.sum);
                    chk("cout", cout, e.cout);
`ifdef SERIAL_ADDER_OVF_EN
                    chk("ovf", ovf, e.ovf);
`endif
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    task automatic start_op(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                            input logic c, input res_t e, input bit push);
        @(negedge clk);
        a     = x;
        b     = y;
        cin   = c;
        start = 1'b1;
        @(posedge clk);
        if (push) exp_q.push_back(e);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n  = 0;
        int nb = 0;
        do begin
            @(negedge clk);
            n++;
            if (busy === 1'b1) nb++;
        end while (done !== 1'b1 && n < 4 * WIDTH);
        chk({name, "_latency"}, n, WIDTH + 1);
        chk({name, "_busy_cycles"}, nb, WIDTH);
    endtask

    initial begin
        res_t r;
        int   n;
        int   nb;
        int   dc0;

        vec[0] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vec[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vec[2] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vec[3] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 1'b0};
        vec[4] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vec[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vec[6] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vec[7] = '{8'h55, 8'hAA, 1'b0, 8'hFF, 1'b0, 1'b0};
        vec[8] = '{8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0, 1'b1};

        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 1'b0);
`ifdef SERIAL_ADDER_OVF_EN
        chk("rst_ovf", ovf, 1'b0);
`endif
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            r.sum  = vec[i].sum;
            r.cout = vec[i].cout;
            r.ovf  = vec[i].ovf;
            start_op(vec[i].a, vec[i].b, vec[i].cin, r, 1'b1);
            wait_done($sformatf("vec%0d", i));
            @(negedge clk);
            chk($sformatf("vec%0d_hold_sum", i), sum, vec[i].sum);
            chk($sformatf("vec%0d_hold_cout", i), cout, vec[i].cout);
            chk($sformatf("vec%0d_done_pulse", i), done, 1'b0);
        end

        // Operands wiggle throughout RUN; the captured values must win
        start_op(8'hA5, 8'h5A, 1'b1, model(8'hA5, 8'h5A, 1'b1), 1'b1);
        nb = 0;
        for (int i = 0; i < WIDTH; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            a   = WIDTH'($urandom);
            b   = WIDTH'($urandom);
            cin = 1'($urandom);
        end
        @(negedge clk);
        chk("toggle_busy_cycles", nb, WIDTH);
        chk("toggle_done", done, 1'b1);
        @(negedge clk);

        // Start pulses while busy must be ignored
        dc0 = done_cnt;
        start_op(8'h3C, 8'h0F, 1'b0, model(8'h3C, 8'h0F, 1'b0), 1'b1);
        nb = 0;
        for (int i = 1; i <= WIDTH; i++) begin
            @(negedge clk);
            if (busy === 1'b1) nb++;
            start = (i == 3 || i == 5);
            a     = 8'hFF;
            b     = 8'hFF;
        end
        @(negedge clk);
        chk("ignore_busy_cycles", nb, WIDTH);
        chk("ignore_done", done, 1'b1);
        repeat (3) @(negedge clk);
        #1;
        chk("ignore_done_count", done_cnt - dc0, 1);

        // Back-to-back: start held through the done cycle
        @(negedge clk);
        a     = 8'h10;
        b     = 8'h20;
        cin   = 1'b0;
        start = 1'b1;
        @(posedge clk);
        exp_q.push_back(model(8'h10, 8'h20, 1'b0));
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (done !== 1'b1 && n < 4 * WIDTH);
        chk("b2b_first_latency", n, WIDTH + 1);
        a = 8'h01;
        b = 8'h02;
        @(posedge clk);
        exp_q.push_back(model(8'h01, 8'h02, 1'b0));
        #1 start = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                chk("b2b_sum_cleared", sum, 8'h00);
                chk("b2b_busy_again", busy, 1'b1);
            end
        end while (done !== 1'b1 && n < 4 * WIDTH);
        chk("b2b_done_spacing", n, WIDTH + 1);
        @(negedge clk);

        // Asynchronous reset in the middle of RUN
        dc0 = done_cnt;
        start_op(8'hFF, 8'h00, 1'b0, model(8'hFF, 8'h00, 1'b0), 1'b0);
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("abort_busy", busy, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_sum", sum, 8'h00);
        chk("abort_cout", cout, 1'b0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (WIDTH + 3) @(negedge clk);
        #1;
        chk("abort_no_done", done_cnt - dc0, 0);
        chk("abort_idle_busy", busy, 1'b0);
        start_op(8'h21, 8'h43, 1'b1, model(8'h21, 8'h43, 1'b1), 1'b1);
        wait_done("after_abort");
        repeat (2) @(negedge clk);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
